// File: rtl/bcd6_display_scan.sv
// -----------------------------------------------------------------------------
// bcd6_display_scan
//   Output stage of the 6-digit BCD frequency counter. LOAD captures the
//   24-bit BCD count into a hold register. The counter can then be cleared and
//   re-gated while the display keeps the captured value. The held value is
//   time-multiplexed onto one shared 7-segment bus. A one-hot, active-low
//   digit select drives the bus, and leading zeros can optionally be blanked.
//
// Parameters
//   SCAN_DIV  clock cycles each digit stays selected (>= 2)
//   BLANK_LZ  1 = blank leading zeros, 0 = show all six digits
//
// Ports
//   CLK      in   system clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   LOAD     in   capture strobe, level-sampled every clock
//   D        in   24-bit BCD count, D[3:0] = units digit
//   SEG      out  {g,f,e,d,c,b,a}, active-high, registered
//   DIG_SEL  out  one-hot active-low digit enable, bit0 = units, registered
//   VALID    out  high once any LOAD has been captured since reset
// -----------------------------------------------------------------------------
module bcd6_display_scan #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        LOAD,
  input  logic [23:0] D,
  output logic [6:0]  SEG,
  output logic [5:0]  DIG_SEL,
  output logic        VALID
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [23:0]   hold_q, hold_d;
  logic          valid_q, valid_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    sel_q, sel_d;

  logic [5:0]    blank;
  logic [3:0]    cur_nib;
  logic          cur_blank;

  // Seven-segment pattern for one BCD nibble. Codes A-F show 'E'.
  function automatic logic [6:0] enc_digit(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h79;
    endcase
    return s;
  endfunction

  // Hold register and VALID flag.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    if (LOAD) begin
      hold_d  = D;
      valid_d = 1'b1;
    end
  end

  // Prescaler and digit index. The index advances on the prescaler's last count.
  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // blank[k]: every nibble from k up to the most significant digit is zero.
  // Any nonzero code, including A-F, stops the blanking run.
  // Digit 0 is never blanked.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    blank      = '0;
    for (int unsigned k = 5; k >= 1; k--) begin
      upper_zero = upper_zero & (hold_q[4*k +: 4] == 4'd0);
      blank[k]   = upper_zero;
    end
  end

  // Select the nibble and blank flag for the digit being displayed now.
  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    case (idx_q)
      3'd0: begin cur_nib = hold_q[3:0];   cur_blank = blank[0]; end
      3'd1: begin cur_nib = hold_q[7:4];   cur_blank = blank[1]; end
      3'd2: begin cur_nib = hold_q[11:8];  cur_blank = blank[2]; end
      3'd3: begin cur_nib = hold_q[15:12]; cur_blank = blank[3]; end
      3'd4: begin cur_nib = hold_q[19:16]; cur_blank = blank[4]; end
      3'd5: begin cur_nib = hold_q[23:20]; cur_blank = blank[5]; end
      default: begin cur_nib = '0; cur_blank = 1'b0; end
    endcase
  end

  // The outputs are built from the pre-edge index and hold value.
  // This gives a one-cycle latency.
  always_comb begin
    seg_d = (BLANK_LZ && cur_blank) ? 7'h00 : enc_digit(cur_nib);
    sel_d = ~(6'b000001 << idx_q);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      sel_q   <= '1;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign SEG     = seg_q;
  assign DIG_SEL = sel_q;
  assign VALID   = valid_q;

endmodule

// File: tb/tb_bcd6_display_scan.sv
module tb_bcd6_display_scan;

  localparam int unsigned DIV = 4;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        LOAD  = 1'b0;
  logic [23:0] D     = '0;

  logic [6:0] seg_bl, seg_nb;
  logic [5:0] sel_bl, sel_nb;
  logic       val_bl, val_nb;

  bcd6_display_scan #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut_bl (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .D(D),
    .SEG(seg_bl), .DIG_SEL(sel_bl), .VALID(val_bl));

  bcd6_display_scan #(.SCAN_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
    .CLK(CLK), .RST_N(RST_N), .LOAD(LOAD), .D(D),
    .SEG(seg_nb), .DIG_SEL(sel_nb), .VALID(val_nb));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model state: the held value, VALID, and the edge count since reset release.
  logic [23:0] m_hold  = '0;
  logic        m_valid = 1'b0;
  int unsigned m_cnt   = 0;

  int unsigned exp_digit;
  logic [6:0]  exp_seg_bl, exp_seg_nb;
  logic [5:0]  exp_sel;
  logic        exp_valid;

  logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};

  task automatic model_reset();
    m_hold  = '0;
    m_valid = 1'b0;
    m_cnt   = 0;
  endtask

  // Advance one clock. The expected outputs come from the state before the edge.
  // Digit shown at edge m is (m / DIV) mod 6.
  task automatic tick();
    int unsigned dgt;
    logic [23:0] upper;
    logic [3:0]  nib;
    dgt        = (m_cnt / DIV) % 6;
    upper      = m_hold >> (4 * dgt);
    nib        = upper[3:0];
    exp_digit  = dgt;
    exp_sel    = ~(6'b000001 << dgt);
    exp_seg_nb = tab[nib];
    exp_seg_bl = (dgt != 0 && upper == 24'd0) ? 7'h00 : tab[nib];
    if (LOAD) begin
      m_hold  = D;
      m_valid = 1'b1;
    end
    @(posedge CLK);
    #1;
    m_cnt++;
    exp_valid = m_valid;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    model_reset();
    #12;
    checks++;
    if (seg_bl !== 7'h00 || seg_nb !== 7'h00) begin
      errors++; $display("FAIL reset_seg: got %h/%h want 00", seg_bl, seg_nb);
    end
    checks++;
    if (sel_bl !== 6'b111111 || sel_nb !== 6'b111111) begin
      errors++; $display("FAIL reset_sel: got %b/%b want 111111", sel_bl, sel_nb);
    end
    checks++;
    if (val_bl !== 1'b0 || val_nb !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b/%b want 0", val_bl, val_nb);
    end
    RST_N = 1'b1;
    tick();
    checks++;
    if (sel_bl !== 6'b111110 || seg_bl !== 7'h3F || val_bl !== 1'b0) begin
      errors++;
      $display("FAIL first_edge: got sel=%b seg=%h valid=%b want 111110 3F 0", sel_bl, seg_bl, val_bl);
    end
  endtask

  task automatic test_scan();
    logic [6:0] seen [6];
    logic [6:0] want [6];
    want = '{7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06};
    D = 24'h123456; LOAD = 1'b1;
    tick();
    LOAD = 1'b0; D = 24'h0;
    for (int unsigned n = 0; n < 60; n++) begin
      tick();
      seen[exp_digit] = seg_bl;
      checks++;
      if (seg_bl !== exp_seg_bl || seg_nb !== exp_seg_nb) begin
        errors++; $display("FAIL scan_seg: got %h/%h want %h/%h", seg_bl, seg_nb, exp_seg_bl, exp_seg_nb);
      end
      checks++;
      if (sel_bl !== exp_sel || sel_nb !== exp_sel) begin
        errors++; $display("FAIL scan_sel: got %b/%b want %b", sel_bl, sel_nb, exp_sel);
      end
      checks++;
      if (val_bl !== exp_valid || val_nb !== exp_valid) begin
        errors++; $display("FAIL scan_valid: got %b/%b want %b", val_bl, val_nb, exp_valid);
      end
    end
    for (int unsigned k = 0; k < 6; k++) begin
      checks++;
      if (seen[k] !== want[k]) begin
        errors++; $display("FAIL scan_digit%0d: got %h want %h", k, seen[k], want[k]);
      end
    end
  endtask

  task automatic test_blanking();
    logic [6:0] sbl [6];
    logic [6:0] snb [6];
    logic [6:0] want [6];
    for (int unsigned pass = 0; pass < 2; pass++) begin
      D = (pass == 0) ? 24'h000042 : 24'h000000;
      LOAD = 1'b1;
      tick();
      LOAD = 1'b0;
      for (int unsigned n = 0; n < 30; n++) begin
        tick();
        if (n >= 2) begin
          sbl[exp_digit] = seg_bl;
          snb[exp_digit] = seg_nb;
        end
        checks++;
        if (seg_bl !== exp_seg_bl || seg_nb !== exp_seg_nb || sel_bl !== exp_sel) begin
          errors++;
          $display("FAIL blank_cycle: got %h/%h sel=%b want %h/%h sel=%b",
                   seg_bl, seg_nb, sel_bl, exp_seg_bl, exp_seg_nb, exp_sel);
        end
      end
      want = (pass == 0) ? '{7'h5B, 7'h66, 7'h00, 7'h00, 7'h00, 7'h00}
                         : '{7'h3F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
      for (int unsigned k = 0; k < 6; k++) begin
        checks++;
        if (sbl[k] !== want[k]) begin
          errors++; $display("FAIL blank_p%0d_digit%0d: got %h want %h", pass, k, sbl[k], want[k]);
        end
      end
      if (pass == 1) begin
        for (int unsigned k = 0; k < 6; k++) begin
          checks++;
          if (snb[k] !== 7'h3F) begin
            errors++; $display("FAIL noblank_zero_digit%0d: got %h want 3F", k, snb[k]);
          end
        end
      end
    end
  endtask

  task automatic test_hold_ignore();
    logic [6:0] seen [6];
    logic [6:0] want [6];
    want = '{7'h4F, 7'h5B, 7'h06, 7'h00, 7'h00, 7'h00};
    D = 24'h000123; LOAD = 1'b1;
    tick();
    LOAD = 1'b0; D = 24'h999999;
    for (int unsigned n = 0; n < 50; n++) begin
      tick();
      seen[exp_digit] = seg_bl;
      checks++;
      if (seg_bl !== exp_seg_bl || seg_nb !== exp_seg_nb || sel_bl !== exp_sel) begin
        errors++;
        $display("FAIL hold_cycle: got %h/%h sel=%b want %h/%h sel=%b",
                 seg_bl, seg_nb, sel_bl, exp_seg_bl, exp_seg_nb, exp_sel);
      end
    end
    for (int unsigned k = 0; k < 6; k++) begin
      checks++;
      if (seen[k] !== want[k]) begin
        errors++; $display("FAIL hold_digit%0d: got %h want %h", k, seen[k], want[k]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [6:0] sbl [6];
    logic [6:0] snb [6];
    logic [6:0] wbl [6];
    logic [6:0] wnb [6];
    wbl = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h79, 7'h00};
    wnb = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h79, 7'h3F};
    D = 24'h0A0000; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int unsigned n = 0; n < 30; n++) begin
      tick();
      if (n >= 2) begin
        sbl[exp_digit] = seg_bl;
        snb[exp_digit] = seg_nb;
      end
    end
    for (int unsigned k = 0; k < 6; k++) begin
      checks++;
      if (sbl[k] !== wbl[k] || snb[k] !== wnb[k]) begin
        errors++;
        $display("FAIL invalid_digit%0d: got %h/%h want %h/%h", k, sbl[k], snb[k], wbl[k], wnb[k]);
      end
    end
  endtask

  task automatic test_random();
    for (int unsigned n = 0; n < 400; n++) begin
      LOAD = ($urandom % 5 == 0);
      D    = 24'($urandom) >> (4 * $urandom_range(0, 6));
      tick();
      checks++;
      if (seg_bl !== exp_seg_bl || seg_nb !== exp_seg_nb) begin
        errors++; $display("FAIL rand_seg: got %h/%h want %h/%h", seg_bl, seg_nb, exp_seg_bl, exp_seg_nb);
      end
      checks++;
      if (sel_bl !== exp_sel || sel_nb !== exp_sel || val_bl !== exp_valid || val_nb !== exp_valid) begin
        errors++;
        $display("FAIL rand_sel_valid: got %b/%b %b/%b want %b %b",
                 sel_bl, sel_nb, val_bl, val_nb, exp_sel, exp_valid);
      end
    end
    LOAD = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    D = 24'h654321; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    for (int unsigned n = 0; n < 60 && !found; n++) begin
      tick();
      if ((m_cnt / DIV) % 6 == 3 && m_cnt % DIV == 2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midreset_reach: got no digit-3 mid-prescale point want one within 60 cycles");
    end
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    checks++;
    if (seg_bl !== 7'h00 || sel_bl !== 6'b111111 || val_bl !== 1'b0 ||
        seg_nb !== 7'h00 || sel_nb !== 6'b111111 || val_nb !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got seg=%h sel=%b valid=%b want 00 111111 0", seg_bl, sel_bl, val_bl);
    end
    #10;
    RST_N = 1'b1;
    tick();
    checks++;
    if (sel_bl !== 6'b111110 || seg_bl !== 7'h3F || val_bl !== 1'b0) begin
      errors++;
      $display("FAIL midreset_restart: got sel=%b seg=%h valid=%b want 111110 3F 0", sel_bl, seg_bl, val_bl);
    end
    for (int unsigned n = 0; n < 30; n++) begin
      tick();
      checks++;
      if (seg_bl !== exp_seg_bl || sel_bl !== exp_sel || val_bl !== exp_valid) begin
        errors++;
        $display("FAIL midreset_scan: got %h %b %b want %h %b %b",
                 seg_bl, sel_bl, val_bl, exp_seg_bl, exp_sel, exp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_blanking();
    test_hold_ignore();
    test_invalid();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
